// File: rtl/gray_rgb_pkg.sv
// Shared types and helpers for the grayscale-to-RGB frame sequencer.
//   state_t  : frame sequencer states (IDLE, RUN, DRAIN)
//   CH_W     : width of one colour channel
//   PIX_W    : width of a packed {red, green, blue} pixel
//   pack_rgb : packs three channels into one destination word
package gray_rgb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CH_W  = 8;
    localparam int PIX_W = 24;

    // Red lands in the most significant byte, blue in the least.
    function automatic logic [PIX_W-1:0] pack_rgb(
        input logic [CH_W-1:0] red,
        input logic [CH_W-1:0] green,
        input logic [CH_W-1:0] blue
    );
        return {red, green, blue};
    endfunction

endpackage

// File: rtl/gray_rgb_frame_ctrl_pixel_fifo.sv
// pixel_fifo: synchronous FIFO holding converted pixels until the
// destination accepts them.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : entry to store
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest entry, read straight from storage
//   full/empty : occupancy flags
//   count      : number of stored entries
// DEPTH must be a power of two; pointers carry one extra wrap bit so
// full and empty are distinguishable.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      diff_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign diff_s    = wr_ptr_r - rd_ptr_r;
    assign count     = CNT_W'(diff_s);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (count == CNT_W'(DEPTH));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/gray_rgb_frame_ctrl.sv
// gray_rgb_frame_ctrl: runs one frame through the grayscale-to-RGB
// converter. Reads N = IMG_W*IMG_H source pixels in raster order, feeds
// them to the converter, buffers the RGB results and writes them as packed
// 24-bit words to the destination under dst_ready_i backpressure.
//   clk, rst                 : clock, synchronous active-high reset
//   start_i                  : frame start pulse (taken only in IDLE)
//   src_rd_en_o/src_addr_o   : source read strobe and address
//   src_data_i               : source data, one cycle after the strobe
//   conv_gray_o/conv_valid_o : converter input pixel and strobe
//   conv_*_i, conv_valid_i   : converter RGB result and strobe
//   dst_wr_en_o/dst_addr_o   : destination write strobe and address
//   dst_data_o, dst_last_o   : packed pixel, final-write marker
//   dst_ready_i              : destination accepts a write this cycle
//   busy_o, frame_done_o     : not-IDLE flag, one-cycle completion pulse
module gray_rgb_frame_ctrl
    import gray_rgb_pkg::*;
#(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              src_rd_en_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [CH_W-1:0]   src_data_i,
    output logic [CH_W-1:0]   conv_gray_o,
    output logic              conv_valid_o,
    input  logic [CH_W-1:0]   conv_red_i,
    input  logic [CH_W-1:0]   conv_green_i,
    input  logic [CH_W-1:0]   conv_blue_i,
    input  logic              conv_valid_i,
    output logic              dst_wr_en_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [PIX_W-1:0]  dst_data_o,
    input  logic              dst_ready_i,
    output logic              dst_last_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int                N         = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam int                OUT_W     = $clog2(FIFO_DEPTH + 1);

    state_t              state_r;
    logic [ADDR_W-1:0]   rd_cnt_r;
    logic [ADDR_W-1:0]   wr_cnt_r;
    logic [OUT_W-1:0]    outstanding_r;
    logic                conv_valid_r;
    logic                frame_done_r;

    logic                rd_en_s;
    logic                wr_en_s;
    logic                fifo_push_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [OUT_W-1:0]    fifo_count_s;
    logic [PIX_W-1:0]    fifo_head_s;

    // Outstanding counts reads still in flight or buffered, so capping it at
    // FIFO_DEPTH means every issued read is guaranteed a FIFO slot.
    assign rd_en_s     = (state_r == RUN) && (outstanding_r < OUT_W'(FIFO_DEPTH));
    assign fifo_push_s = conv_valid_i && (state_r != IDLE) && !fifo_full_s;
    assign wr_en_s     = !fifo_empty_s && dst_ready_i;

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (pack_rgb(conv_red_i, conv_green_i, conv_blue_i)),
        .pop       (wr_en_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign src_rd_en_o  = rd_en_s;
    assign src_addr_o   = rd_cnt_r;
    assign conv_gray_o  = src_data_i;
    assign conv_valid_o = conv_valid_r;
    assign dst_wr_en_o  = wr_en_s;
    assign dst_addr_o   = wr_cnt_r;
    // Head storage is not cleared on reset, so mask it while nothing is buffered.
    assign dst_data_o   = (fifo_count_s != OUT_W'(0)) ? fifo_head_s : {PIX_W{1'b0}};
    assign dst_last_o   = wr_en_s && (wr_cnt_r == LAST_ADDR);
    assign busy_o       = (state_r != IDLE);
    assign frame_done_o = frame_done_r;

    // Frame FSM with read/write counters, outstanding tracking and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            rd_cnt_r      <= {ADDR_W{1'b0}};
            wr_cnt_r      <= {ADDR_W{1'b0}};
            outstanding_r <= {OUT_W{1'b0}};
            conv_valid_r  <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            conv_valid_r <= rd_en_s;
            if (rd_en_s) begin
                rd_cnt_r <= rd_cnt_r + ADDR_W'(1);
            end
            if (wr_en_s) begin
                wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
            end
            // A slot freed by this cycle's write is only visible next cycle.
            case ({rd_en_s, wr_en_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - OUT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        rd_cnt_r      <= {ADDR_W{1'b0}};
                        wr_cnt_r      <= {ADDR_W{1'b0}};
                        outstanding_r <= {OUT_W{1'b0}};
                        state_r       <= RUN;
                    end
                end
                RUN: begin
                    if (rd_en_s && (rd_cnt_r == LAST_ADDR)) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_en_s && (wr_cnt_r == LAST_ADDR)) begin
                        state_r      <= IDLE;
                        frame_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_rgb_frame_ctrl.sv
// Bench for gray_rgb_frame_ctrl: an 8-pixel (4x2) instance for directed
// frame, backpressure, start-ignore, reset and back-to-back sequences, and a
// 16x16 instance under random destination readiness. Source memory holds
// 0x10+addr; the converter model replicates gray into R, G and B one cycle later.
module tb_gray_rgb_frame_ctrl;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 4x2 instance ----------------
    logic          a_start, a_rd, a_cvo, a_cvi, a_wr, a_ready, a_last, a_busy, a_done;
    logic [AW-1:0] a_raddr, a_waddr;
    logic [7:0]    a_src, a_gray, a_r, a_g, a_b;
    logic [23:0]   a_data;

    gray_rgb_frame_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(AW), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start),
        .src_rd_en_o(a_rd), .src_addr_o(a_raddr), .src_data_i(a_src),
        .conv_gray_o(a_gray), .conv_valid_o(a_cvo),
        .conv_red_i(a_r), .conv_green_i(a_g), .conv_blue_i(a_b), .conv_valid_i(a_cvi),
        .dst_wr_en_o(a_wr), .dst_addr_o(a_waddr), .dst_data_o(a_data),
        .dst_ready_i(a_ready), .dst_last_o(a_last), .busy_o(a_busy), .frame_done_o(a_done)
    );

    // ---------------- 16x16 instance ----------------
    logic          b_start, b_rd, b_cvo, b_cvi, b_wr, b_ready, b_last, b_busy, b_done;
    logic [AW-1:0] b_raddr, b_waddr;
    logic [7:0]    b_src, b_gray, b_r, b_g, b_b;
    logic [23:0]   b_data;

    gray_rgb_frame_ctrl #(.IMG_W(16), .IMG_H(16), .ADDR_W(AW), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start),
        .src_rd_en_o(b_rd), .src_addr_o(b_raddr), .src_data_i(b_src),
        .conv_gray_o(b_gray), .conv_valid_o(b_cvo),
        .conv_red_i(b_r), .conv_green_i(b_g), .conv_blue_i(b_b), .conv_valid_i(b_cvi),
        .dst_wr_en_o(b_wr), .dst_addr_o(b_waddr), .dst_data_o(b_data),
        .dst_ready_i(b_ready), .dst_last_o(b_last), .busy_o(b_busy), .frame_done_o(b_done)
    );

    // Source memories and converter models (data valid one cycle after strobe).
    always @(posedge clk) begin
        if (rst) begin
            a_src <= 8'h00; a_cvi <= 1'b0; a_r <= 8'h00; a_g <= 8'h00; a_b <= 8'h00;
            b_src <= 8'h00; b_cvi <= 1'b0; b_r <= 8'h00; b_g <= 8'h00; b_b <= 8'h00;
        end else begin
            a_src <= a_rd ? (8'h10 + a_raddr[7:0]) : 8'h00;
            b_src <= b_rd ? (8'h10 + b_raddr[7:0]) : 8'h00;
            a_cvi <= a_cvo; a_r <= a_gray; a_g <= a_gray; a_b <= a_gray;
            b_cvi <= b_cvo; b_r <= b_gray; b_g <= b_gray; b_b <= b_gray;
        end
    end

    // Write logs, done counts and an issued-minus-written occupancy model.
    logic [AW-1:0] a_wa_log[$], b_wa_log[$];
    logic [23:0]   a_wd_log[$], b_wd_log[$];
    int a_ndone = 0, b_ndone = 0, a_out = 0, b_out = 0, a_ovf = 0, b_ovf = 0;

    always @(negedge clk) begin
        if (a_wr) begin a_wa_log.push_back(a_waddr); a_wd_log.push_back(a_data); end
        if (b_wr) begin b_wa_log.push_back(b_waddr); b_wd_log.push_back(b_data); end
        if (a_done) a_ndone <= a_ndone + 1;
        if (b_done) b_ndone <= b_ndone + 1;
        if (rst) begin
            a_out <= 0; b_out <= 0;
        end else begin
            if (a_rd && a_out >= 4) a_ovf <= a_ovf + 1;
            if (b_rd && b_out >= 4) b_ovf <= b_ovf + 1;
            a_out <= a_out + (a_rd ? 1 : 0) - (a_wr ? 1 : 0);
            b_out <= b_out + (b_rd ? 1 : 0) - (b_wr ? 1 : 0);
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        start;
        logic        ready;
        logic        rd;
        logic [15:0] raddr;
        logic        cv;
        logic [7:0]  gray;
        logic        wr;
        logic [15:0] waddr;
        logic [23:0] data;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vt [0:12];

    function automatic vec_t mk(input logic st, input logic rd, input logic [15:0] ra,
                                input logic cv, input logic [7:0] gy, input logic wr,
                                input logic [15:0] wa, input logic [23:0] d,
                                input logic la, input logic bs, input logic dn);
        vec_t v;
        v.start = st; v.ready = 1'b1; v.rd = rd; v.raddr = ra; v.cv = cv; v.gray = gy;
        v.wr = wr; v.waddr = wa; v.data = d; v.last = la; v.busy = bs; v.done = dn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Must be called at a negedge; all outputs of the 4x2 instance are zero.
    task automatic check_a_zero(input string tag);
        check({tag, "_rd"}, {31'd0, a_rd}, 32'd0);
        check({tag, "_raddr"}, {16'd0, a_raddr}, 32'd0);
        check({tag, "_cv"}, {31'd0, a_cvo}, 32'd0);
        check({tag, "_gray"}, {24'd0, a_gray}, 32'd0);
        check({tag, "_wr"}, {31'd0, a_wr}, 32'd0);
        check({tag, "_waddr"}, {16'd0, a_waddr}, 32'd0);
        check({tag, "_data"}, {8'd0, a_data}, 32'd0);
        check({tag, "_last"}, {31'd0, a_last}, 32'd0);
        check({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, a_done}, 32'd0);
    endtask

    // Runs with start low until frame_done_o is seen; returns at that negedge.
    task automatic wait_done_a(input int budget, input string tag);
        bit seen = 1'b0;
        a_start = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (a_done) seen = 1'b1;
            else tick();
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic verify_a(input int base, input string tag);
        check({tag, "_nwrites"}, a_wa_log.size() - base, 32'd8);
        for (int i = 0; i < 8 && base + i < a_wa_log.size(); i++) begin
            logic [7:0] v;
            v = 8'h10 + 8'(i);
            check({tag, "_waddr"}, {16'd0, a_wa_log[base + i]}, i);
            check({tag, "_wdata"}, {8'd0, a_wd_log[base + i]}, {8'd0, v, v, v});
        end
    endtask

    initial begin
        int s, d;
        logic rdhit [0:14];

        rst = 1'b1; a_start = 1'b0; a_ready = 1'b1; b_start = 1'b0; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_a_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // ---- Table-driven nominal frame, cycle 0 = start ----
        vt[0]  = mk(1'b1, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 16'd0, 24'h000000, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b1, 16'd0, 1'b0, 8'h00, 1'b0, 16'd0, 24'h000000, 1'b0, 1'b1, 1'b0);
        vt[2]  = mk(1'b0, 1'b1, 16'd1, 1'b1, 8'h10, 1'b0, 16'd0, 24'h000000, 1'b0, 1'b1, 1'b0);
        vt[3]  = mk(1'b0, 1'b1, 16'd2, 1'b1, 8'h11, 1'b0, 16'd0, 24'h000000, 1'b0, 1'b1, 1'b0);
        vt[4]  = mk(1'b0, 1'b1, 16'd3, 1'b1, 8'h12, 1'b1, 16'd0, 24'h101010, 1'b0, 1'b1, 1'b0);
        vt[5]  = mk(1'b0, 1'b1, 16'd4, 1'b1, 8'h13, 1'b1, 16'd1, 24'h111111, 1'b0, 1'b1, 1'b0);
        vt[6]  = mk(1'b0, 1'b1, 16'd5, 1'b1, 8'h14, 1'b1, 16'd2, 24'h121212, 1'b0, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 1'b1, 16'd6, 1'b1, 8'h15, 1'b1, 16'd3, 24'h131313, 1'b0, 1'b1, 1'b0);
        vt[8]  = mk(1'b0, 1'b1, 16'd7, 1'b1, 8'h16, 1'b1, 16'd4, 24'h141414, 1'b0, 1'b1, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 8'h17, 1'b1, 16'd5, 24'h151515, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 1'b0, 16'd0, 1'b0, 8'h00, 1'b1, 16'd6, 24'h161616, 1'b0, 1'b1, 1'b0);
        vt[11] = mk(1'b0, 1'b0, 16'd0, 1'b0, 8'h00, 1'b1, 16'd7, 24'h171717, 1'b1, 1'b1, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 16'd0, 24'h000000, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 13; i++) begin
            a_start = vt[i].start;
            a_ready = vt[i].ready;
            @(negedge clk);
            check($sformatf("nom_c%0d_rd", i), {31'd0, a_rd}, {31'd0, vt[i].rd});
            if (vt[i].rd) check($sformatf("nom_c%0d_raddr", i), {16'd0, a_raddr}, {16'd0, vt[i].raddr});
            check($sformatf("nom_c%0d_cv", i), {31'd0, a_cvo}, {31'd0, vt[i].cv});
            if (vt[i].cv) check($sformatf("nom_c%0d_gray", i), {24'd0, a_gray}, {24'd0, vt[i].gray});
            check($sformatf("nom_c%0d_wr", i), {31'd0, a_wr}, {31'd0, vt[i].wr});
            if (vt[i].wr) begin
                check($sformatf("nom_c%0d_waddr", i), {16'd0, a_waddr}, {16'd0, vt[i].waddr});
                check($sformatf("nom_c%0d_data", i), {8'd0, a_data}, {8'd0, vt[i].data});
            end
            check($sformatf("nom_c%0d_last", i), {31'd0, a_last}, {31'd0, vt[i].last});
            check($sformatf("nom_c%0d_busy", i), {31'd0, a_busy}, {31'd0, vt[i].busy});
            check($sformatf("nom_c%0d_done", i), {31'd0, a_done}, {31'd0, vt[i].done});
            tick();
        end
        a_start = 1'b0;
        repeat (3) tick();

        // ---- Backpressure: ready low in cycles 3..12 ----
        s = a_wa_log.size(); d = a_ndone;
        for (int c = 0; c < 60; c++) begin
            a_start = (c == 0);
            a_ready = !(c >= 3 && c <= 12);
            @(negedge clk);
            if (c <= 14) rdhit[c] = a_rd;
            tick();
        end
        a_start = 1'b0; a_ready = 1'b1;
        for (int c = 1; c <= 4; c++) check($sformatf("bp_read_c%0d", c), {31'd0, rdhit[c]}, 32'd1);
        begin
            int nr = 0;
            for (int c = 5; c <= 12; c++) nr += rdhit[c] ? 1 : 0;
            check("bp_reads_c5_12", nr, 32'd0);
        end
        check("bp_read_c13", {31'd0, rdhit[13]}, 32'd0);
        check("bp_read_c14", {31'd0, rdhit[14]}, 32'd1);
        check("bp_ndone", a_ndone - d, 32'd1);
        verify_a(s, "bp");

        // ---- start_i during RUN and DRAIN is ignored ----
        s = a_wa_log.size(); d = a_ndone;
        for (int c = 0; c < 30; c++) begin
            a_start = (c == 0 || c == 5 || c == 10);
            tick();
        end
        a_start = 1'b0;
        check("ign_ndone", a_ndone - d, 32'd1);
        check("ign_busy_end", {31'd0, a_busy}, 32'd0);
        verify_a(s, "ign");

        // ---- Reset in cycle 6 mid-frame ----
        for (int c = 0; c <= 6; c++) begin
            a_start = (c == 0);
            rst = (c == 6);
            tick();
        end
        rst = 1'b0;
        s = a_wa_log.size(); d = a_ndone;
        @(negedge clk);
        check_a_zero("midrst");
        @(posedge clk); #1;
        repeat (10) tick();
        check("midrst_no_done", a_ndone - d, 32'd0);
        check("midrst_no_writes", a_wa_log.size() - s, 32'd0);
        s = a_wa_log.size(); d = a_ndone;
        a_start = 1'b1;
        tick();
        wait_done_a(60, "postrst");
        tick();
        check("postrst_ndone", a_ndone - d, 32'd1);
        verify_a(s, "postrst");
        repeat (2) tick();

        // ---- Back-to-back frames: restart in the frame_done cycle ----
        s = a_wa_log.size();
        a_start = 1'b1;
        tick();
        wait_done_a(60, "b2b1");
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        verify_a(s, "b2b1");
        s = a_wa_log.size();
        @(negedge clk);
        check("b2b_first_rd", {31'd0, a_rd}, 32'd1);
        check("b2b_first_raddr", {16'd0, a_raddr}, 32'd0);
        tick();
        wait_done_a(60, "b2b2");
        tick();
        verify_a(s, "b2b2");
        check("a_no_overflow", a_ovf, 32'd0);

        // ---- 16x16 frame with random destination readiness ----
        s = b_wa_log.size();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 4000 && !seen; c++) begin
                b_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (b_done) seen = 1'b1;
                else tick();
            end
            check("rnd_done_seen", {31'd0, seen}, 32'd1);
        end
        tick();
        b_ready = 1'b1;
        check("rnd_nwrites", b_wa_log.size() - s, 32'd256);
        for (int i = 0; i < 256 && s + i < b_wa_log.size(); i++) begin
            logic [7:0] v;
            v = 8'h10 + 8'(i);
            check("rnd_waddr", {16'd0, b_wa_log[s + i]}, i);
            check("rnd_wdata", {8'd0, b_wd_log[s + i]}, {8'd0, v, v, v});
        end
        check("b_no_overflow", b_ovf, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_rgb_frame_ctrl.md
# gray_rgb_frame_ctrl

Frame sequencer for the grayscale-to-RGB output stage of the edge-detection pipeline. It reads a full frame of 8-bit grayscale pixels from the source buffer in raster order and feeds them to the converter (`grayscale_to_rgb`). It collects the converter's RGB results and writes them as packed 24-bit words to the destination buffer, honouring destination backpressure. Start/busy/frame-done handshakes let the top-level pipeline controller run it once per frame.

## Interface
Parameters:
- `IMG_W`, default 256: pixels per row.
- `IMG_H`, default 256: rows per frame.
- `ADDR_W`, default 16: source and destination address width. Must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- `FIFO_DEPTH`, default 4: result buffer depth. Must be at least 4 for one-pixel-per-cycle throughput. Power of two.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `start_i` input 1: one-cycle frame start request. Honoured only in IDLE.
- `src_rd_en_o` output 1: source read strobe.
- `src_addr_o` output ADDR_W: source read address.
- `src_data_i` input 8: source read data. Valid exactly 1 cycle after `src_rd_en_o`.
- `conv_gray_o` output 8: converter `grayscale_i`. Combinational copy of `src_data_i`.
- `conv_valid_o` output 1: converter `done_i`. Equals `src_rd_en_o` delayed by 1 cycle.
- `conv_red_i`, `conv_green_i`, `conv_blue_i` input 8 each: converter outputs.
- `conv_valid_i` input 1: converter `done_o`.
- `dst_wr_en_o` output 1: destination write strobe.
- `dst_addr_o` output ADDR_W: destination write address.
- `dst_data_o` output 24: packed pixel {red, green, blue}.
- `dst_ready_i` input 1: destination accepts a write this cycle.
- `dst_last_o` output 1: marks the final write of the frame.
- `busy_o` output 1: high whenever the state is not IDLE.
- `frame_done_o` output 1: one-cycle pulse on frame completion.

## Operation
- Frame size is N = IMG_W*IMG_H pixels.
- The state machine has three states:
  - IDLE. `start_i` clears the read, write and outstanding counters and moves to RUN.
  - RUN. Issues reads. When the read for address N-1 issues, moves to DRAIN.
  - DRAIN. Issues no reads. When the write for address N-1 is accepted, moves to IDLE and registers `frame_done_o`=1 for one cycle.
- Issue rule: `src_rd_en_o` = (state==RUN) && (outstanding < FIFO_DEPTH).
  - `outstanding` is a registered count: reads issued minus writes accepted.
  - `outstanding` changes by +1 on a read, −1 on an accepted write, and 0 when both happen in the same cycle.
  - A write accepted in the current cycle does not free a slot until the next cycle.
- Addressing:
  - `src_addr_o` is a read counter, 0..N-1, incremented on each read.
  - `dst_addr_o` is a write counter, 0..N-1, incremented on each accepted write.
  - Both counters are ADDR_W wide and do not wrap within a frame.
- Result buffer:
  - Every `conv_valid_i` pushes {red,green,blue} into a FIFO_DEPTH synchronous FIFO.
  - The issue rule guarantees no overflow. A push into a full FIFO is a design error; the bench flags it with an assertion.
- Write rule: `dst_wr_en_o` = FIFO not empty && `dst_ready_i`.
  - `dst_data_o` is the FIFO head, which is registered storage.
  - A write is accepted in a cycle where `dst_wr_en_o`=1.
- `dst_last_o` = `dst_wr_en_o` && (write counter == N-1).
- `start_i` in RUN or DRAIN is ignored. It is not queued.
- `conv_valid_i` outside RUN/DRAIN is ignored. It is not pushed.
- Reset:
  - All outputs go to 0. Counters and `outstanding` go to 0, the FIFO is emptied, and the state goes to IDLE.
  - Reset mid-frame discards in-flight pixels. No partial-frame `frame_done_o` is generated.

## Timing
- `start_i` sampled high in cycle 0:
  - First read in cycle 1.
  - `conv_valid_o` and `conv_gray_o` in cycle 2.
  - `conv_valid_i` in cycle 3.
  - FIFO head valid in cycle 4; first write in cycle 4 if `dst_ready_i`=1.
- With `dst_ready_i` held high:
  - Reads are issued in cycles 1..N.
  - Writes occur in cycles 4..N+3.
  - `frame_done_o`=1 in cycle N+4, the cycle `busy_o` first reads 0.
  - A new `start_i` is honoured from cycle N+4 onward.
- While `dst_ready_i` is low:
  - Reads continue until `outstanding` reaches FIFO_DEPTH, then stop.
  - Issue resumes in the cycle after the first accepted write.
- End-to-end latency from read to write is 3 cycles minimum.

## Structure
- Package `gray_rgb_pkg` holds:
  - the state enum {IDLE, RUN, DRAIN};
  - the packed-pixel width constant (24) and the per-channel width constant (8);
  - a function that packs {r,g,b} into the 24-bit word.
- Sub-module `pixel_fifo` is a parameterised synchronous FIFO. It has width and depth parameters, push, pop, full, empty and a count output.
- The top level contains the FSM, the counters and the issue/write logic.

## Test plan
- Test configuration is IMG_W=4, IMG_H=2 (N=8); converter instantiated; `dst_ready_i`=1; source holds values 0x10+addr.
  - `start_i` at cycle 0 → writes in cycles 4..11 to addresses 0..7 with data 0x101010..0x171717.
  - `dst_last_o` is high in cycle 11.
  - `frame_done_o` is high in cycle 12.
- Backpressure: hold `dst_ready_i`=0 for cycles 3..12.
  - Exactly 4 reads are issued, at cycles 1..4, and no reads in cycles 5..12.
  - No FIFO overflow.
  - After ready returns, all 8 pixels are written in order with correct data.
- Random `dst_ready_i` (50%) over a 16×16 frame → 256 writes, addresses strictly 0..255 in order, data matches source, no overflow.
- `start_i` pulsed in cycle 5 and again during DRAIN → ignored; exactly one frame of 8 writes and one `frame_done_o`.
- `rst` asserted in cycle 6 mid-frame:
  - All outputs are 0 in the following cycle and `busy_o`=0.
  - No `frame_done_o`.
  - A fresh `start_i` yields a complete, correct frame starting at address 0.
- Back-to-back frames: `start_i` in the `frame_done_o` cycle → the second frame's first read occurs the next cycle, and the read address restarts at 0.
